// File: rtl/smux_nx1_reg.sv
// Registered N-to-1 signed multiplexer with a valid/ready output stage.
// The channel comes from the sel port or from an internal round-robin scan counter.
module smux_nx1_reg #(
  parameter int DATAWIDTH  = 8,
  parameter int NUM_INPUTS = 4,
  parameter int SELWIDTH   = 2
) (
  input  logic                            Clk,
  input  logic                            Rst,
  input  logic [NUM_INPUTS*DATAWIDTH-1:0] a,
  input  logic [SELWIDTH-1:0]             sel,
  input  logic                            mode,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic [DATAWIDTH-1:0]            d,
  output logic                            d_valid,
  input  logic                            d_ready,
  output logic [SELWIDTH-1:0]             d_chan,
  output logic                            sel_err
);

  // One extra bit so that NUM_INPUTS == 2**SELWIDTH can still be represented.
  localparam logic [SELWIDTH:0]   NUM_IN_EXT = (SELWIDTH + 1)'(NUM_INPUTS);
  localparam logic [SELWIDTH-1:0] LAST_CH    = SELWIDTH'(NUM_INPUTS - 1);

  logic [DATAWIDTH-1:0] res_q, res_d;
  logic [SELWIDTH-1:0]  chan_q, chan_d;
  logic [SELWIDTH-1:0]  cnt_q, cnt_d;
  logic                 valid_q, valid_d;
  logic                 err_q, err_d;

  logic                 accept;
  logic                 sel_oor;
  logic [SELWIDTH-1:0]  ch;
  logic [DATAWIDTH-1:0] ch_data;

  assign in_ready = !valid_q || d_ready;
  assign accept   = in_valid && in_ready;
  assign ch       = mode ? cnt_q : sel;
  assign sel_oor  = !mode && ({1'b0, sel} >= NUM_IN_EXT);

  // An index that matches no channel falls through to the zero default.
  always_comb begin
    ch_data = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (ch == SELWIDTH'(i)) ch_data = a[i*DATAWIDTH +: DATAWIDTH];
    end
  end

  always_comb begin
    // NOTE: every next-state signal is defaulted to its hold value first so no path leaves it unassigned (no latch).
    res_d   = res_q;
    chan_d  = chan_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    err_d   = err_q;
    if (accept) begin
      res_d   = ch_data;
      chan_d  = ch;
      valid_d = 1'b1;
      if (sel_oor) err_d = 1'b1;
      if (mode)    cnt_d = (cnt_q == LAST_CH) ? '0 : cnt_q + 1'b1;
    end else if (valid_q && d_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    if (Rst) begin
      res_q   <= '0;
      chan_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      res_q   <= res_d;
      chan_q  <= chan_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign d       = res_q;
  assign d_chan  = chan_q;
  assign d_valid = valid_q;
  assign sel_err = err_q;

endmodule

// File: tb/tb_smux_nx1_reg.sv
// Bench for smux_nx1_reg: a 4-channel and a 3-channel instance share one stimulus stream
// and are compared each cycle against a rule-level model, plus directed literal checks.
module tb_smux_nx1_reg;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [31:0] a_bus;
  logic [1:0]  sel;
  logic        mode, in_valid, d_ready;

  logic [7:0]  d4, d3;
  logic [1:0]  chan4, chan3;
  logic        valid4, valid3, ready4, ready3, err4, err3;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state per instance: [0] = 4 channels, [1] = 3 channels.
  int          nin[2] = '{4, 3};
  int          m_cnt[2];
  int          m_chan[2];
  logic [7:0]  m_d[2];
  bit          m_valid[2];
  bit          m_err[2];

  always #5 Clk = ~Clk;

  smux_nx1_reg #(.DATAWIDTH(8), .NUM_INPUTS(4), .SELWIDTH(2)) dut4 (
    .Clk(Clk), .Rst(Rst), .a(a_bus), .sel(sel), .mode(mode),
    .in_valid(in_valid), .in_ready(ready4), .d(d4), .d_valid(valid4),
    .d_ready(d_ready), .d_chan(chan4), .sel_err(err4)
  );

  smux_nx1_reg #(.DATAWIDTH(8), .NUM_INPUTS(3), .SELWIDTH(2)) dut3 (
    .Clk(Clk), .Rst(Rst), .a(a_bus[23:0]), .sel(sel), .mode(mode),
    .in_valid(in_valid), .in_ready(ready3), .d(d3), .d_valid(valid3),
    .d_ready(d_ready), .d_chan(chan3), .sel_err(err3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Channel k of a packed byte bus, found by shifting it down to the bottom.
  function automatic logic [7:0] chan_val(input logic [31:0] bus, input int k);
    return 8'(bus >> (8 * k));
  endfunction

  task automatic model_edge(input int k);
    bit rdy, acc;
    int ch;
    rdy = !m_valid[k] || d_ready;
    acc = in_valid && rdy;
    if (Rst) begin
      m_cnt[k] = 0; m_chan[k] = 0; m_d[k] = 8'h00; m_valid[k] = 0; m_err[k] = 0;
    end else if (acc) begin
      ch          = mode ? m_cnt[k] : int'(sel);
      m_chan[k]   = ch;
      m_valid[k]  = 1;
      m_d[k]      = (ch < nin[k]) ? chan_val(a_bus, ch) : 8'h00;
      if (!mode && int'(sel) >= nin[k]) m_err[k] = 1;
      if (mode) m_cnt[k] = (m_cnt[k] + 1) % nin[k];
    end else if (m_valid[k] && d_ready) begin
      m_valid[k] = 0;
    end
  endtask

  task automatic compare_all();
    check("n4_d",       {24'b0, d4},     {24'b0, m_d[0]});
    check("n4_chan",    {30'b0, chan4},  32'(m_chan[0]));
    check("n4_valid",   {31'b0, valid4}, {31'b0, m_valid[0]});
    check("n4_err",     {31'b0, err4},   {31'b0, m_err[0]});
    check("n4_inready", {31'b0, ready4}, {31'b0, (!m_valid[0] || d_ready)});
    check("n3_d",       {24'b0, d3},     {24'b0, m_d[1]});
    check("n3_chan",    {30'b0, chan3},  32'(m_chan[1]));
    check("n3_valid",   {31'b0, valid3}, {31'b0, m_valid[1]});
    check("n3_err",     {31'b0, err3},   {31'b0, m_err[1]});
    check("n3_inready", {31'b0, ready3}, {31'b0, (!m_valid[1] || d_ready)});
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then compare.
  task automatic step(input bit rst, input bit iv, input bit dr, input bit md,
                      input logic [1:0] s, input logic [31:0] av);
    Rst = rst; in_valid = iv; d_ready = dr; mode = md; sel = s; a_bus = av;
    #1;
    compare_all();
    @(posedge Clk);
    model_edge(0);
    model_edge(1);
    #1;
    compare_all();
  endtask

  localparam logic [31:0] A_DEF = 32'h807F_FF05;

  initial begin
    logic [7:0] exp_seq_d[4];
    logic [7:0] held_d;
    logic [1:0] held_chan;
    Rst = 1'b1; in_valid = 1'b0; d_ready = 1'b0; mode = 1'b0; sel = '0; a_bus = '0;
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0; m_chan[k] = 0; m_d[k] = 8'h00; m_valid[k] = 0; m_err[k] = 0;
    end
    @(posedge Clk); #1;

    // Reset with upstream pushing and downstream blocked.
    step(1, 1, 0, 0, 2'd1, A_DEF);
    step(1, 1, 0, 0, 2'd1, A_DEF);
    check("rst_d",     {24'b0, d4},     32'h0);
    check("rst_valid", {31'b0, valid4}, 32'h0);
    check("rst_chan",  {30'b0, chan4},  32'h0);
    check("rst_err",   {31'b0, err4},   32'h0);
    step(0, 0, 0, 0, 2'd0, A_DEF);
    check("idle_inready", {31'b0, ready4}, 32'h1);

    // Explicit select over all four channels, back to back.
    exp_seq_d = '{8'h05, 8'hFF, 8'h7F, 8'h80};
    for (int s = 0; s < 4; s++) begin
      step(0, 1, 1, 0, 2'(s), A_DEF);
      check("sel_d",     {24'b0, d4},     {24'b0, exp_seq_d[s]});
      check("sel_chan",  {30'b0, chan4},  32'(s));
      check("sel_valid", {31'b0, valid4}, 32'h1);
    end
    // sel=3 on the 3-channel instance is out of range.
    check("oor_d",    {24'b0, d3},    32'h0);
    check("oor_chan", {30'b0, chan3}, 32'h3);
    check("oor_err",  {31'b0, err3},  32'h1);
    check("oor_err4", {31'b0, err4},  32'h0);

    // Round-robin wrap, then an explicit transfer, then resume scanning.
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 1, 1, 2'd3, A_DEF);
      check("rr_chan", {30'b0, chan4}, 32'(i % 4));
      check("rr_d",    {24'b0, d4},    {24'b0, exp_seq_d[i % 4]});
    end
    step(0, 1, 1, 0, 2'd0, A_DEF);
    step(0, 1, 1, 1, 2'd0, A_DEF);
    check("rr_resume", {30'b0, chan4}, 32'h2);
    check("err_sticky", {31'b0, err3}, 32'h1);

    // Backpressure: output frozen while inputs keep changing.
    held_d = d4; held_chan = chan4;
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 1, 2'($urandom), $urandom);
      check("stall_d",       {24'b0, d4},     {24'b0, held_d});
      check("stall_chan",    {30'b0, chan4},  {30'b0, held_chan});
      check("stall_inready", {31'b0, ready4}, 32'h0);
    end
    step(0, 1, 1, 1, 2'd0, 32'h1122_3344);
    check("unstall_chan",  {30'b0, chan4},  32'h3);
    check("unstall_d",     {24'b0, d4},     32'h11);
    check("unstall_valid", {31'b0, valid4}, 32'h1);

    // Reset in the middle of a stall with the scan counter at 2.
    step(1, 0, 0, 0, 2'd0, A_DEF);
    step(0, 1, 1, 1, 2'd0, A_DEF);
    step(0, 1, 1, 1, 2'd0, A_DEF);
    step(0, 0, 0, 1, 2'd0, A_DEF);
    step(1, 1, 0, 1, 2'd0, A_DEF);
    check("midrst_valid", {31'b0, valid4}, 32'h0);
    check("midrst_d",     {24'b0, d4},     32'h0);
    check("midrst_err3",  {31'b0, err3},   32'h0);
    step(0, 1, 1, 1, 2'd3, A_DEF);
    check("midrst_chan", {30'b0, chan4}, 32'h0);

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) == 0), $urandom_range(0, 3) != 0,
           $urandom_range(0, 2) != 0, 1'($urandom), 2'($urandom), $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
